// File: rtl/seq_div_ctrl.sv
// seq_div_ctrl
// Multi-cycle unsigned restoring divider serving DIV/REM-class ALU operations.
// A single (N+1)-bit trial subtract is reused across N iterations, producing one
// quotient bit per cycle under control of a three-state FSM and a down counter.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       request pulse, only honoured in IDLE
//   dividend    unsigned dividend, captured on the accepting edge
//   divisor     unsigned divisor, captured on the accepting edge
//   busy        high while iterations are running
//   done        one-cycle pulse when quotient/remainder/div_by_zero are updated
//   quotient    quotient, held until the next result is published
//   remainder   remainder, held until the next result is published
//   div_by_zero set together with done when the divisor was zero
module seq_div_ctrl #(
    parameter int N  = 32,
    parameter int CW = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [CW-1:0] ITER_CNT = CW'(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(1);

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic          dz_pend;

    // Working registers: partial remainder is one bit wider than the operands
    // so that a shifted-in remainder never overflows before the trial subtract.
    logic [N:0]    r_acc;
    logic [N-1:0]  q_acc;
    logic [N-1:0]  d_reg;

    logic [N:0]    r_shift;
    logic [N:0]    r_trial;

    // (N+1)-bit subtract done as add-of-complement plus one; bit N of the
    // result is the borrow that decides restore vs. keep.
    function automatic logic [N:0] trial_sub(input logic [N:0] a, input logic [N-1:0] b);
        return a + ~{1'b0, b} + {{N{1'b0}}, 1'b1};
    endfunction

    always_comb begin
        r_shift = {r_acc[N-1:0], q_acc[N-1]};
        r_trial = trial_sub(r_shift, d_reg);
    end

    // Control path: FSM, counter and published results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            count       <= '0;
            dz_pend     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            // Result is fixed; skip iterations and publish next cycle.
                            dz_pend <= 1'b1;
                            state   <= S_FIN;
                        end else begin
                            dz_pend <= 1'b0;
                            count   <= ITER_CNT;
                            busy    <= 1'b1;
                            state   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    count <= count - LAST_CNT;
                    if (count == LAST_CNT) begin
                        busy  <= 1'b0;
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    done        <= 1'b1;
                    quotient    <= q_acc;
                    remainder   <= r_acc[N-1:0];
                    div_by_zero <= dz_pend;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath: operand capture and one restoring iteration per RUN cycle.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            d_reg <= divisor;
            if (divisor == '0) begin
                q_acc <= '1;
                r_acc <= {1'b0, dividend};
            end else begin
                q_acc <= dividend;
                r_acc <= '0;
            end
        end else if (state == S_RUN) begin
            q_acc <= {q_acc[N-2:0], ~r_trial[N]};
            r_acc <= r_trial[N] ? r_shift : r_trial;
        end
    end

endmodule

// File: doc/seq_div_ctrl.md
Name: seq_div_ctrl

Overview:
- Multi-cycle unsigned restoring divider for the 32-bit ALU.
- One shared (N+1)-bit subtract path, driven by a small FSM and an iteration counter.
- Produces one quotient bit per cycle.
- Sits beside the combinational ALU and serves DIV/REM-class operations through a start/done handshake.

Parameters:
N, 32, operand/quotient/remainder width in bits (N >= 2)
CW, $clog2(N)+1, iteration counter width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  request pulse; sampled only in IDLE
dividend  in  N  unsigned dividend; latched on accepted start
divisor  in  N  unsigned divisor; latched on accepted start
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse: results valid
quotient  out  N  quotient; held until next accepted start
remainder  out  N  remainder; held until next accepted start
div_by_zero  out  1  set with done when divisor was 0; held like results

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
  - Reset overrides all other inputs, including mid-division; the partial result is discarded.
- States: IDLE, RUN, FIN.
- IDLE, start=1, divisor!=0:
  - Latch D=divisor, Q=dividend, R=0 ((N+1)-bit), count=N, div_by_zero=0.
  - Go to RUN; busy=1 next cycle.
- IDLE, start=1, divisor==0:
  - quotient = all ones, remainder = dividend, div_by_zero=1.
  - Go to FIN (no RUN cycles).
- RUN, one iteration per cycle:
  - Shift {R,Q} left by 1, giving R_s (N+1 bits).
  - Compute T = R_s - {1'b0,D}: (N+1)-bit two's-complement subtract, i.e. add of the complement plus 1.
  - If T[N]==0: R=T, Q[0]=1. Otherwise R=R_s (restore), Q[0]=0.
  - count decrements; leave RUN after the iteration where count reaches 0.
- FIN:
  - done=1 for exactly one cycle, busy=0, quotient=Q, remainder=R[N-1:0].
  - Next state IDLE unconditionally.
- Latency:
  - start accepted at edge t (divisor!=0): done high in the cycle after edge t+N+1, i.e. N RUN cycles + 1 FIN cycle.
  - Divide by zero: done in the cycle after edge t+1.
- start while busy or in FIN: ignored; no re-latch, no queuing.
- Operand inputs are don't-care except on the accepting edge; changing them during RUN has no effect.
- Outputs quotient/remainder/div_by_zero change only in FIN or on reset.
- Arithmetic is unsigned; no overflow is possible for divisor!=0.
- Internal R is N+1 bits so that dividend=2^N-1 with a large divisor restores correctly.
- Invariants: busy and done never high together; done is never high two consecutive cycles.

Test Plan:
- 100 / 7, single start pulse -> exactly 33 cycles later done=1 for 1 cycle, quotient=14, remainder=2, div_by_zero=0; busy high 32 cycles.
- 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0. Then 0xFFFFFFFF / 0x80000000 -> quotient=1, remainder=0x7FFFFFFF.
- 5 / 9 -> quotient=0, remainder=5. Then 0 / 3 -> quotient=0, remainder=0.
- 1234 / 0 -> done 2 cycles after start, quotient=0xFFFFFFFF, remainder=1234, div_by_zero=1. Next 10/3 clears div_by_zero and gives quotient=3, remainder=1.
- 100/7 started, second start with 50/5 pulsed at RUN cycle 10 -> ignored; result 14/2. A following start in IDLE yields 10/0.
- 100/7 started, rst=1 at RUN cycle 15 for one cycle -> next cycle all outputs 0, IDLE, no done. A fresh start of 9/2 -> quotient=4, remainder=1.
